// File: rtl/mc_mips_core.sv
// Multi-cycle MIPS subset core sharing one req/ready memory port for fetch and data.
// Define PERF_CNT_EN to add the cyc_cnt / ret_cnt performance counter outputs.
module mc_mips_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          REG_ADDR_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_out,
  output logic        retire,
  output logic        halted
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
`endif
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEMADDR,
    S_MEMRD,
    S_WB_MEM,
    S_MEMWR,
    S_BRANCH,
    S_HALT
  } state_t;

  state_t state, state_n;

  logic [31:0] pc, ir, a_reg, b_reg, alu_out, mdr;
  logic [31:0] regs [NUM_REGS];

  logic [5:0]            opcode, funct;
  logic [REG_ADDR_W-1:0] rs_idx, rt_idx, rd_idx;
  logic [31:0]           imm_ext, rs_val, rt_val, alu_res;
  logic                  funct_ok;

  logic                  req_c, we_c, retire_n;
  logic [31:0]           addr_c, wdata_c;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [31:0]           rf_wdata;

  logic unused_ir;

  assign opcode    = ir[31:26];
  assign funct     = ir[5:0];
  assign rs_idx    = ir[21 +: REG_ADDR_W];
  assign rt_idx    = ir[16 +: REG_ADDR_W];
  assign rd_idx    = ir[11 +: REG_ADDR_W];
  assign imm_ext   = {{16{ir[15]}}, ir[15:0]};
  assign unused_ir = ^ir[10:6];

  assign rs_val = (rs_idx == '0) ? 32'd0 : regs[rs_idx];
  assign rt_val = (rt_idx == '0) ? 32'd0 : regs[rt_idx];

  assign funct_ok = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                    (funct == F_OR)  || (funct == F_SLT);

  always_comb begin
    alu_res = 32'd0;
    case (funct)
      F_ADD:   alu_res = a_reg + b_reg;
      F_SUB:   alu_res = a_reg - b_reg;
      F_AND:   alu_res = a_reg & b_reg;
      F_OR:    alu_res = a_reg | b_reg;
      F_SLT:   alu_res = ($signed(a_reg) < $signed(b_reg)) ? 32'd1 : 32'd0;
      default: alu_res = 32'd0;
    endcase
  end

  // Memory outputs are decoded from state so a zero-wait transfer finishes
  // in the cycle the request appears; reset forces them quiet immediately.
  assign mem_req   = req_c & ~reset;
  assign mem_we    = we_c & ~reset;
  assign mem_addr  = reset ? 32'd0 : addr_c;
  assign mem_wdata = reset ? 32'd0 : wdata_c;
  assign pc_out    = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_FETCH;
      retire <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_n;
      retire <= retire_n;
      halted <= (state_n == S_HALT);
    end
  end

  always_comb begin
    state_n  = state;
    req_c    = 1'b0;
    we_c     = 1'b0;
    addr_c   = 32'd0;
    wdata_c  = 32'd0;
    retire_n = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = 32'd0;
    case (state)
      S_FETCH: begin
        req_c  = 1'b1;
        addr_c = {pc[31:2], 2'b00};
        if (mem_ready) state_n = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_R:         state_n = funct_ok ? S_EXEC_R : S_HALT;
          OP_ADDI:      state_n = S_EXEC_I;
          OP_LW, OP_SW: state_n = S_MEMADDR;
          OP_BEQ:       state_n = S_BRANCH;
          OP_J: begin
            state_n  = S_FETCH;
            retire_n = 1'b1;
          end
          default:      state_n = S_HALT;
        endcase
      end
      S_EXEC_R: state_n = S_WB_R;
      S_WB_R: begin
        rf_we    = 1'b1;
        rf_waddr = rd_idx;
        rf_wdata = alu_out;
        retire_n = 1'b1;
        state_n  = S_FETCH;
      end
      S_EXEC_I: state_n = S_WB_I;
      S_WB_I: begin
        rf_we    = 1'b1;
        rf_waddr = rt_idx;
        rf_wdata = alu_out;
        retire_n = 1'b1;
        state_n  = S_FETCH;
      end
      S_MEMADDR: state_n = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        req_c  = 1'b1;
        addr_c = {alu_out[31:2], 2'b00};
        if (mem_ready) state_n = S_WB_MEM;
      end
      S_WB_MEM: begin
        rf_we    = 1'b1;
        rf_waddr = rt_idx;
        rf_wdata = mdr;
        retire_n = 1'b1;
        state_n  = S_FETCH;
      end
      S_MEMWR: begin
        req_c   = 1'b1;
        we_c    = 1'b1;
        addr_c  = {alu_out[31:2], 2'b00};
        wdata_c = b_reg;
        if (mem_ready) begin
          retire_n = 1'b1;
          state_n  = S_FETCH;
        end
      end
      S_BRANCH: begin
        retire_n = 1'b1;
        state_n  = S_FETCH;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  // DECODE precomputes the branch target while the operands are read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= 32'd0;
      a_reg   <= 32'd0;
      b_reg   <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a_reg   <= rs_val;
          b_reg   <= rt_val;
          alu_out <= pc + (imm_ext << 2);
          if (opcode == OP_J) pc <= {pc[31:28], ir[25:0], 2'b00};
        end
        S_EXEC_R:           alu_out <= alu_res;
        S_EXEC_I, S_MEMADDR: alu_out <= a_reg + imm_ext;
        S_MEMRD: begin
          if (mem_ready) mdr <= mem_rdata;
        end
        S_BRANCH: begin
          if (a_reg == b_reg) pc <= alu_out;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
    end else if (rf_we && (rf_waddr != '0)) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt <= 32'd0;
      ret_cnt <= 32'd0;
    end else begin
      if (!halted) cyc_cnt <= cyc_cnt + 32'd1;
      if (retire_n) ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule
